// File: rtl/if_id_buf.sv
// if_id_buf: fetch-to-decode FIFO holding {pc, inst} pairs with valid/ready handshake and flush.
// Define IFID_MISALIGN_CHK_EN to store a per-entry PC misalignment flag presented on misalign_o.
module if_id_buf #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            inst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  output logic [XLEN-1:0]            pc_o,
  output logic [XLEN-1:0]            inst_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       misalign_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign ready_o = count != CW'(DEPTH);
  assign valid_o = count != '0;
  assign count_o = count;
  assign push = valid_i && ready_o && !flush_i;
  assign pop = valid_o && ready_i && !flush_i;
  assign pc_o = valid_o ? pc_mem[rd_ptr] : '0;
  assign inst_o = valid_o ? inst_mem[rd_ptr] : NOP_INST;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
    end
  end
  // Entry storage is deliberately left unreset; valid_o masks stale contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr] <= pc_i;
      inst_mem[wr_ptr] <= inst_i;
    end
  end
`ifdef IFID_MISALIGN_CHK_EN
  logic mis_mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (push) mis_mem[wr_ptr] <= pc_i[1:0] != 2'b00;
  end
  assign misalign_o = valid_o && mis_mem[rd_ptr];
`else
  assign misalign_o = 1'b0;
`endif
endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Fetch-to-decode buffer. Sits directly downstream of the instruction ROM.
- Captures each {pc, inst} pair the ROM produces and holds it in a small FIFO.
- Presents the oldest entry to the decode stage with a valid/ready handshake.
- Absorbs decode stalls without losing fetched instructions. Supports a single-cycle pipeline flush for jumps and branches.

Parameters:
- XLEN, 32, width of PC and instruction words
- DEPTH, 2, number of FIFO entries; power of two, >= 2
- NOP_INST, 32'h00000013, instruction word driven on inst_o when the buffer is empty (addi x0,x0,0)

Ports:
- clk_i  input  1  system clock; all state updates on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- pc_i  input  XLEN  PC of the fetched instruction (from ROM pc_o)
- inst_i  input  XLEN  fetched instruction word (from ROM inst_o)
- valid_i  input  1  pc_i/inst_i hold a valid fetch this cycle
- ready_o  output  1  buffer can accept a fetch this cycle; the PC stage advances only when valid_i && ready_o
- flush_i  input  1  discard all buffered and incoming instructions
- pc_o  output  XLEN  PC of the head entry
- inst_o  output  XLEN  instruction of the head entry
- valid_o  output  1  head entry is valid
- ready_i  input  1  decode accepts the head entry this cycle
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- misalign_o  output  1  head entry PC not word aligned (see Optional Feature)

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset rst_n_i is asynchronous and active-low. Assertion immediately clears read pointer, write pointer and count to 0.
  - Entry storage is not reset.
  - Reset values: valid_o=0, ready_o=1, count_o=0, pc_o=0, inst_o=NOP_INST, misalign_o=0.
  - Reset mid-operation drops all entries. The first edge after deassertion behaves as from empty.
- Push:
  - Condition: valid_i && ready_o && !flush_i.
  - Writes {pc_i, inst_i} at the write pointer. The write pointer increments modulo DEPTH (natural wrap, pointer width $clog2(DEPTH)).
- Pop:
  - Condition: valid_o && ready_i && !flush_i.
  - The read pointer increments modulo DEPTH.
- Count:
  - Push only: count+1. Pop only: count-1. Both: count unchanged, both pointers advance.
- Combinational outputs (from registered state):
  - ready_o = (count != DEPTH).
  - valid_o = (count != 0).
- Head data:
  - When count != 0, pc_o and inst_o are the head entry.
  - When empty, pc_o=0 and inst_o=NOP_INST.
- Latency:
  - A pushed entry appears on valid_o on the cycle after the push edge.
  - There is no combinational bypass from inputs to outputs.
- Full:
  - ready_o=0 even if ready_i=1 the same cycle. There is no pop-and-push pass-through when full.
  - A full buffer with a pop frees one slot on the next cycle.
- Empty:
  - valid_o=0. ready_i is ignored and count does not underflow.
- Flush:
  - On an edge with flush_i=1, pointers and count go to 0.
  - Any same-cycle push or pop is discarded.
  - Flush has priority over push and pop.
  - valid_o=0 on the following cycle. ready_o is unaffected by flush_i within the same cycle.
- Output stability:
  - While valid_o=1 && ready_i=0, pc_o, inst_o and misalign_o hold stable until popped or flushed.

Optional Feature:
- Macro name: IFID_MISALIGN_CHK_EN.
- With macro defined:
  - Each entry stores an extra bit, pc_i[1:0] != 2'b00, captured at push.
  - misalign_o presents the head entry's bit when valid_o=1, else 0.
  - Decode uses it to raise an instruction-address-misaligned exception.
- Without macro:
  - No extra storage. misalign_o is tied to 0.
  - Port list is identical in both builds.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n_i=0 mid-cycle with 1 entry buffered.
  - Required: outputs go immediately to valid_o=0, ready_o=1, count_o=0, inst_o=32'h00000013. After release, push pc=0x80000000 -> valid_o=1 with pc_o=0x80000000 next cycle.
- Streaming:
  - Stimulus: valid_i=1, ready_i=1 continuously, pc 0x0, 0x4, 0x8...
  - Required: count_o steady at 1. Each pc appears on pc_o exactly one cycle after its push. No drops or duplicates over 20 pushes.
- Full/backpressure:
  - Stimulus: ready_i=0, push 0x10, 0x14, 0x18.
  - Required: count_o=2 and ready_o=0 after two pushes. 0x18 is not accepted (PC holds). Raising ready_i pops 0x10 then 0x14 in order. ready_o returns to 1 the cycle after the first pop.
- Wrap-around:
  - Stimulus: alternate push/pop patterns for 10 entries with DEPTH=2 and DEPTH=4.
  - Required: output order matches input order across pointer wrap.
- Flush priority:
  - Stimulus: count=2, flush_i=1 together with valid_i=1 (pc 0x40) and ready_i=1.
  - Required: next cycle count_o=0 and valid_o=0. 0x40 is never presented.
- Misalign (macro on):
  - Stimulus: push pc=0x102.
  - Required: misalign_o=1 with that head. Push pc=0x104 -> misalign_o=0. With macro off, misalign_o=0 always.
